tone_pulse_gen: RTL and testbench
=================================

Name: tone_pulse_gen

Overview:
- Generates the square-wave `input_pulse` stimulus that the proportional tuner measures. It is the transmitting end of the tuner's pulse input.
- Produces a programmable-period 50% duty square wave, either continuously or as a counted burst.
- Period updates are glitch-free and take effect only on a period boundary.
- Used on the demo board and in the bench to drive known note frequencies into the tuner.

Parameters:
- WIDTH, 16, width of the half-period register, in clk cycles.
- BURST_W, 8, width of the burst-length and period counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  level; when low, aborts any activity and holds the block idle.
- half_period  in  WIDTH  requested half-period, in clk cycles.
- period_load  in  1  single-cycle strobe; captures half_period into the pending register.
- burst_len  in  BURST_W  number of full periods per burst; 0 means continuous.
- start  in  1  single-cycle strobe; begins generation.
- pulse_out  out  1  generated square wave, registered.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a burst completes normally.
- period_count  out  BURST_W  full periods completed since start; wraps at 2^BURST_W.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - pulse_out=0, busy=0, done=0, period_count=0.
  - Active and pending half-period registers both = 2.
  - Phase counter=0, burst counter=0.
- Clamping:
  - The value captured on period_load is max(half_period, 2).
  - Values 0 and 1 load as 2, so the minimum output period is 4 clk cycles.
- Pending/active period:
  - period_load writes the pending register in any state.
  - The active register copies pending at the start of every high phase (the IDLE->HIGH transition and every LOW->HIGH transition), never mid-period.
  - Loading in the same cycle as start applies to the first period.
- States:
  - IDLE: pulse_out=0.
    - start & enable -> HIGH. In the same edge: load active from pending (including a same-cycle period_load), phase counter=1, period_count=0, latch burst_len into the burst target.
    - pulse_out=1 on the first cycle after the start strobe (latency 1).
    - start while enable=0 is ignored.
  - HIGH: pulse_out=1 for exactly H cycles, where H = active half-period. Then -> LOW, phase counter=1.
  - LOW: pulse_out=0 for exactly H cycles. At the end of the low phase:
    - period_count increments.
    - If burst target != 0 and the new count == target: -> IDLE, done=1 for exactly that one cycle.
    - Otherwise -> HIGH, reloading active from pending.
- Simultaneous events:
  - start while busy is ignored; it does not restart the burst or reset period_count.
  - enable=0 in any state: on the next edge, state=IDLE, pulse_out=0, done=0, period_count holds its value. This applies even if it coincides with burst completion.
  - A burst_len change after start has no effect until the next start.
- Wrap-around:
  - In continuous mode, period_count wraps 255->0 and generation continues.
  - In burst mode with target=255, done fires at the 255th completed period.
- Reset mid-operation: immediate return to reset values, with no done pulse.
- Outputs:
  - All outputs are registered; no combinational input-to-output paths.
  - busy = (state != IDLE), also registered.

Test Plan:
- Basic continuous output: reset; period_load with half_period=5; start, burst_len=0. Required response:
  - pulse_out rises 1 cycle after start.
  - Pattern is 5 high / 5 low repeating.
  - period_count = 3 after 30 cycles.
  - done never asserts.
- Burst of 3 periods: half_period=4, burst_len=3, start. Required response:
  - pulse_out shows 3 periods of 8 cycles each.
  - done is high for 1 cycle, coinciding with the return to IDLE.
  - busy falls at the same cycle as done.
  - pulse_out stays 0 afterwards; period_count=3.
- Glitch-free period change: run continuous at half_period=6. Load 3 at cycle 2 of a high phase. Required response:
  - The current period completes as 6+6.
  - The next period is 3+3.
  - No shortened high or low phase anywhere.
- Clamp: load half_period=0, start a burst of 2. Required response: pattern is 2 high / 2 low, twice, then done.
- Abort and ignored start: during the 2nd period of a burst of 5:
  - Drop enable. Required: next cycle pulse_out=0, busy=0, no done; period_count holds 1.
  - Assert start while enable=0. Required: ignored.
  - Re-enable and start again. Required: period_count restarts from 0.
- Async reset mid-high: assert rst between clock edges during a high phase. Required response: pulse_out=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tone_pulse_gen_if.sv
// Control/status bundle for tone_pulse_gen: period/burst programming inputs and
// the generated waveform plus its status flags.
interface tone_pulse_gen_if #(
    parameter int WIDTH   = 16,
    parameter int BURST_W = 8
);
    logic               enable;
    logic [WIDTH-1:0]   half_period;
    logic               period_load;
    logic [BURST_W-1:0] burst_len;
    logic               start;
    logic               pulse_out;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] period_count;

    modport master (
        output enable, half_period, period_load, burst_len, start,
        input  pulse_out, busy, done, period_count
    );

    modport slave (
        input  enable, half_period, period_load, burst_len, start,
        output pulse_out, busy, done, period_count
    );
endinterface

// File: rtl/tone_pulse_gen.sv
// Programmable 50%-duty square-wave generator, continuous or counted burst.
// A new half-period is staged in a pending register and adopted only at a high-phase start.
module tone_pulse_gen #(
    parameter int WIDTH   = 16,
    parameter int BURST_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    tone_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    localparam logic [WIDTH-1:0] MIN_HALF = WIDTH'(2);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   active_q, active_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [WIDTH-1:0]   phase_q, phase_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic [BURST_W-1:0] target_q, target_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            active_q  <= MIN_HALF;
            pending_q <= MIN_HALF;
            phase_q   <= '0;
            count_q   <= '0;
            target_q  <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            count_q   <= count_d;
            target_q  <= target_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // NOTE: every next-state signal gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        phase_d   = phase_q;
        count_d   = count_q;
        target_d  = target_q;
        done_d    = 1'b0;

        if (bus.period_load)
            pending_d = (bus.half_period < MIN_HALF) ? MIN_HALF : bus.half_period;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = HIGH;
                    active_d = pending_d;
                    phase_d  = WIDTH'(1);
                    count_d  = '0;
                    target_d = bus.burst_len;
                end
            end
            HIGH: begin
                if (phase_q == active_q) begin
                    state_d = LOW;
                    phase_d = WIDTH'(1);
                end else begin
                    phase_d = phase_q + WIDTH'(1);
                end
            end
            LOW: begin
                if (phase_q == active_q) begin
                    count_d = count_q + BURST_W'(1);
                    phase_d = WIDTH'(1);
                    if (target_q != '0 && count_d == target_q) begin
                        state_d = IDLE;
                        phase_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = HIGH;
                        active_d = pending_d;
                    end
                end else begin
                    phase_d = phase_q + WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything, including a coincident burst completion.
        if (!bus.enable) begin
            state_d  = IDLE;
            active_d = active_q;
            phase_d  = '0;
            count_d  = count_q;
            target_d = target_q;
            done_d   = 1'b0;
        end

        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
    end

    assign bus.pulse_out    = pulse_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.period_count = count_q;
endmodule

// File: tb/tb_tone_pulse_gen.sv
// Directed self-checking bench for tone_pulse_gen: continuous, burst, period change,
// clamp, abort, wrap-around and asynchronous reset.
module tb_tone_pulse_gen;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    tone_pulse_gen_if #(.WIDTH(16), .BURST_W(8)) bus ();

    tone_pulse_gen #(.WIDTH(16), .BURST_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load a half-period and start a run with the given burst length in the same cycle.
    task automatic load_and_start(input logic [15:0] hp, input logic [7:0] blen);
        bus.half_period = hp;
        bus.period_load = 1'b1;
        bus.burst_len   = blen;
        bus.start       = 1'b1;
        step();
        bus.period_load = 1'b0;
        bus.start       = 1'b0;
    endtask

    task automatic abort();
        bus.enable = 1'b0;
        step();
        bus.enable = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.enable      = 1'b1;
        bus.half_period = '0;
        bus.period_load = 1'b0;
        bus.burst_len   = '0;
        bus.start       = 1'b0;

        // Reset state
        #1;
        check("rst_pulse", 32'(bus.pulse_out), 32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_done",  32'(bus.done),      32'd0);
        check("rst_count", 32'(bus.period_count), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Reset value of pending is 2: burst of 1 with no load gives 2 high / 2 low
        bus.burst_len = 8'd1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rstp_pulse[%0d]", i), 32'(bus.pulse_out), 32'((i / 2) % 2 == 0));
            step();
        end
        check("rstp_done", 32'(bus.done), 32'd1);
        step();

        // Continuous at half-period 5
        bus.half_period = 16'd5;
        bus.period_load = 1'b1;
        step();
        bus.period_load = 1'b0;
        bus.burst_len   = 8'd0;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            check($sformatf("cont_pulse[%0d]", i), 32'(bus.pulse_out), 32'((i / 5) % 2 == 0));
            check($sformatf("cont_done[%0d]", i),  32'(bus.done), 32'd0);
            step();
        end
        check("cont_count30", 32'(bus.period_count), 32'd3);
        abort();
        check("cont_abort_busy",  32'(bus.busy),      32'd0);
        check("cont_abort_pulse", 32'(bus.pulse_out), 32'd0);
        check("cont_abort_count", 32'(bus.period_count), 32'd3);

        // Burst of 3 at half-period 4; burst_len change mid-run must be ignored
        load_and_start(16'd4, 8'd3);
        for (int i = 0; i < 24; i++) begin
            if (i == 2) bus.burst_len = 8'd1;
            check($sformatf("burst_pulse[%0d]", i), 32'(bus.pulse_out), 32'((i / 4) % 2 == 0));
            check($sformatf("burst_busy[%0d]", i),  32'(bus.busy), 32'd1);
            check($sformatf("burst_done[%0d]", i),  32'(bus.done), 32'd0);
            step();
        end
        check("burst_end_done",  32'(bus.done),      32'd1);
        check("burst_end_busy",  32'(bus.busy),      32'd0);
        check("burst_end_pulse", 32'(bus.pulse_out), 32'd0);
        check("burst_end_count", 32'(bus.period_count), 32'd3);
        step();
        check("burst_after_done",  32'(bus.done),      32'd0);
        check("burst_after_pulse", 32'(bus.pulse_out), 32'd0);
        check("burst_after_count", 32'(bus.period_count), 32'd3);

        // Glitch-free change: 6 -> 3 loaded on the 2nd high cycle of the first period
        load_and_start(16'd6, 8'd0);
        for (int i = 0; i < 21; i++) begin
            logic exp_p;
            if (i < 6)       exp_p = 1'b1;
            else if (i < 12) exp_p = 1'b0;
            else             exp_p = ((i - 12) / 3) % 2 == 0;
            check($sformatf("chg_pulse[%0d]", i), 32'(bus.pulse_out), 32'(exp_p));
            bus.half_period = 16'd3;
            bus.period_load = (i == 1);
            step();
        end
        bus.period_load = 1'b0;
        abort();

        // Clamp: half-period 0 loads as 2
        bus.half_period = 16'd0;
        bus.period_load = 1'b1;
        step();
        bus.period_load = 1'b0;
        bus.burst_len   = 8'd2;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clamp_pulse[%0d]", i), 32'(bus.pulse_out), 32'((i / 2) % 2 == 0));
            step();
        end
        check("clamp_done", 32'(bus.done), 32'd1);
        check("clamp_busy", 32'(bus.busy), 32'd0);
        step();

        // Abort during 2nd period of a burst of 5, start ignored while disabled
        load_and_start(16'd3, 8'd5);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ab_pulse[%0d]", i), 32'(bus.pulse_out), 32'((i / 3) % 2 == 0));
            step();
        end
        check("ab_count_before", 32'(bus.period_count), 32'd1);
        bus.enable = 1'b0;
        step();
        check("ab_pulse", 32'(bus.pulse_out), 32'd0);
        check("ab_busy",  32'(bus.busy),      32'd0);
        check("ab_done",  32'(bus.done),      32'd0);
        check("ab_count", 32'(bus.period_count), 32'd1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ab_dis_start_busy",  32'(bus.busy),      32'd0);
        check("ab_dis_start_pulse", 32'(bus.pulse_out), 32'd0);
        check("ab_dis_start_count", 32'(bus.period_count), 32'd1);
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        check("re_busy",  32'(bus.busy),      32'd1);
        check("re_pulse", 32'(bus.pulse_out), 32'd1);
        check("re_count", 32'(bus.period_count), 32'd0);
        // Start while busy at i=7 must not restart the burst
        for (int i = 1; i < 30; i++) begin
            step();
            bus.start = (i == 7);
            check($sformatf("re_pulse[%0d]", i), 32'(bus.pulse_out), 32'((i / 3) % 2 == 0));
            check($sformatf("re_done[%0d]", i),  32'(bus.done), 32'd0);
            if (i == 8) check("re_busy_start_count", 32'(bus.period_count), 32'd1);
        end
        bus.start = 1'b0;
        step();
        check("re_end_done",  32'(bus.done),         32'd1);
        check("re_end_count", 32'(bus.period_count), 32'd5);
        step();

        // Continuous wrap of period_count at half-period 2
        load_and_start(16'd2, 8'd0);
        repeat (1020) step();
        check("wrap_count255", 32'(bus.period_count), 32'd255);
        repeat (4) step();
        check("wrap_count0", 32'(bus.period_count), 32'd0);
        check("wrap_busy",   32'(bus.busy),         32'd1);
        check("wrap_pulse",  32'(bus.pulse_out),    32'd1);
        abort();

        // Burst of 255 completes at the 255th period
        load_and_start(16'd2, 8'd255);
        repeat (1019) step();
        check("b255_pre_done", 32'(bus.done), 32'd0);
        check("b255_pre_busy", 32'(bus.busy), 32'd1);
        step();
        check("b255_done",  32'(bus.done),         32'd1);
        check("b255_count", 32'(bus.period_count), 32'd255);
        check("b255_busy",  32'(bus.busy),         32'd0);
        step();

        // Asynchronous reset in the middle of a high phase
        load_and_start(16'd4, 8'd0);
        step();
        check("ar_pre_pulse", 32'(bus.pulse_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_pulse", 32'(bus.pulse_out), 32'd0);
        check("ar_busy",  32'(bus.busy),      32'd0);
        check("ar_count", 32'(bus.period_count), 32'd0);
        #1;
        rst = 1'b0;
        step();
        check("ar_idle_busy", 32'(bus.busy), 32'd0);
        check("ar_idle_done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
